// File: rtl/pretrig_capture_buffer_pkg.sv
// Shared types for the pre/post-trigger capture buffer: FSM encoding and a
// constant-foldable ceil(log2) helper for sizing RAM addresses.
package pretrig_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_POST = 2'd2,
    ST_READ = 2'd3
  } state_t;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/pretrig_capture_buffer_if.sv
// Readout stream of the capture buffer: valid/ready words with an end-of-record
// marker. The buffer drives the master side, the consumer the slave side.
interface pretrig_capture_buffer_if #(
  parameter int DATA_WIDTH = 40
);
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  rd_ready;
  logic                  rd_last;

  modport master (output rd_data, output rd_valid, output rd_last, input rd_ready);
  modport slave  (input rd_data, input rd_valid, input rd_last, output rd_ready);
endinterface

// File: rtl/pretrig_capture_buffer_sdp_ram.sv
// Simple dual-port sample RAM: synchronous write, registered read. Kept free of
// resets so it maps onto block RAM.
module sdp_ram
  import pretrig_capture_pkg::*;
#(
  parameter int WIDTH = 40,
  parameter int DEPTH = 2048,
  localparam int AW = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/pretrig_capture_buffer.sv
// Pre/post-trigger capture buffer: circular sample RAM filled while armed, then
// the record is streamed out oldest-first through a 2-entry skid buffer.
module pretrig_capture_buffer
  import pretrig_capture_pkg::*;
#(
  parameter int SAMPLE_WIDTH    = 10,
  parameter int CHANNELS        = 4,
  parameter int ADDR_WIDTH      = 11,
  parameter bit ALLOW_SHORT_PRE = 1'b0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             arm,
  input  logic                             abort,
  input  logic [ADDR_WIDTH:0]              pre_samples,
  input  logic [ADDR_WIDTH:0]              total_samples,
  input  logic [CHANNELS*SAMPLE_WIDTH-1:0] wr_data,
  input  logic                             wr_ce,
  input  logic                             trigger,
  pretrig_capture_buffer_if.master         rd,
  output logic                             pre_filled,
  output logic                             capture_active,
  output logic                             done
);

  localparam int WIDTH = CHANNELS * SAMPLE_WIDTH;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);

  state_t state_reg, state_next;
  logic [ADDR_WIDTH-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [ADDR_WIDTH:0]   pre_reg, total_reg, pre_cnt_reg, post_cnt_reg, post_need_reg, rd_cnt_reg;
  logic                  ram_valid_reg, ram_last_reg;
  logic [WIDTH-1:0]      ram_q, out_data_reg, skid_data_reg;
  logic                  out_valid_reg, out_last_reg, skid_valid_reg, skid_last_reg, done_reg;

  logic [ADDR_WIDTH:0] total_clamp, pre_clamp, post_need_now;
  logic [1:0]          pipe_cnt;
  logic capturing, wr_en, pre_full, trig_accept, post_end, pop, last_accept, issue, done_next;

  assign total_clamp   = (total_samples == '0 || total_samples > DEPTH_CNT) ? DEPTH_CNT : total_samples;
  assign pre_clamp     = (pre_samples >= total_clamp) ? total_clamp - CNT_ONE : pre_samples;
  assign capturing     = (state_reg == ST_PRE) || (state_reg == ST_POST);
  assign wr_en         = capturing && wr_ce;
  assign pre_full      = (pre_cnt_reg == pre_reg);
  assign trig_accept   = (state_reg == ST_PRE) && wr_ce && trigger && (pre_full || ALLOW_SHORT_PRE);
  assign post_need_now = total_reg - pre_cnt_reg;
  assign post_end      = (state_reg == ST_POST) && wr_ce && (post_cnt_reg + CNT_ONE == post_need_reg);
  assign pop           = out_valid_reg && rd.rd_ready;
  assign last_accept   = pop && out_last_reg;

  // A read issued now lands in the skid stage two edges later; only issue when
  // the words already in flight leave room for it even if nothing is popped then.
  assign pipe_cnt = 2'(out_valid_reg) + 2'(skid_valid_reg) + 2'(ram_valid_reg);
  assign issue    = (state_reg == ST_READ) && (rd_cnt_reg != total_reg) && (pipe_cnt < 2'd2 || pop);

  always_comb begin
    state_next = state_reg;
    done_next  = 1'b0;
    if (abort) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: if (arm) state_next = ST_PRE;
        ST_PRE:  if (trig_accept) state_next = (post_need_now == CNT_ONE) ? ST_READ : ST_POST;
        ST_POST: if (post_end) state_next = ST_READ;
        ST_READ: begin
          if (last_accept) begin
            state_next = ST_IDLE;
            done_next  = 1'b1;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      pre_reg        <= '0;
      total_reg      <= '0;
      pre_cnt_reg    <= '0;
      post_cnt_reg   <= '0;
      post_need_reg  <= '0;
      rd_cnt_reg     <= '0;
      ram_valid_reg  <= 1'b0;
      ram_last_reg   <= 1'b0;
      out_data_reg   <= '0;
      out_valid_reg  <= 1'b0;
      out_last_reg   <= 1'b0;
      skid_data_reg  <= '0;
      skid_valid_reg <= 1'b0;
      skid_last_reg  <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      done_reg <= done_next;
      if (state_reg == ST_IDLE && arm) begin
        pre_reg      <= pre_clamp;
        total_reg    <= total_clamp;
        wr_ptr_reg   <= '0;
        pre_cnt_reg  <= '0;
        post_cnt_reg <= '0;
      end
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (trig_accept) begin
        // The trigger sample is the first post sample; the record starts pre_act back.
        post_cnt_reg  <= CNT_ONE;
        post_need_reg <= post_need_now;
        rd_ptr_reg    <= wr_ptr_reg - pre_cnt_reg[ADDR_WIDTH-1:0];
        rd_cnt_reg    <= '0;
      end else if (state_reg == ST_PRE && wr_ce && !pre_full) begin
        pre_cnt_reg <= pre_cnt_reg + CNT_ONE;
      end
      if (state_reg == ST_POST && wr_ce) post_cnt_reg <= post_cnt_reg + CNT_ONE;

      ram_valid_reg <= issue;
      if (issue) begin
        rd_ptr_reg   <= rd_ptr_reg + PTR_ONE;
        rd_cnt_reg   <= rd_cnt_reg + CNT_ONE;
        ram_last_reg <= (rd_cnt_reg + CNT_ONE == total_reg);
      end

      if (!out_valid_reg || pop) begin
        if (skid_valid_reg) begin
          out_data_reg   <= skid_data_reg;
          out_last_reg   <= skid_last_reg;
          out_valid_reg  <= 1'b1;
          skid_valid_reg <= ram_valid_reg;
          skid_last_reg  <= ram_valid_reg && ram_last_reg;
          if (ram_valid_reg) skid_data_reg <= ram_q;
        end else begin
          out_valid_reg <= ram_valid_reg;
          out_last_reg  <= ram_valid_reg && ram_last_reg;
          if (ram_valid_reg) out_data_reg <= ram_q;
        end
      end else if (ram_valid_reg) begin
        skid_valid_reg <= 1'b1;
        skid_last_reg  <= ram_last_reg;
        skid_data_reg  <= ram_q;
      end

      if (state_next != ST_READ) begin
        ram_valid_reg  <= 1'b0;
        out_valid_reg  <= 1'b0;
        out_last_reg   <= 1'b0;
        skid_valid_reg <= 1'b0;
        skid_last_reg  <= 1'b0;
      end
    end
  end

  sdp_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr_reg),
    .wdata (wr_data),
    .re    (issue),
    .raddr (rd_ptr_reg),
    .rdata (ram_q)
  );

  assign rd.rd_data     = out_data_reg;
  assign rd.rd_valid    = out_valid_reg;
  assign rd.rd_last     = out_last_reg;
  assign pre_filled     = (state_reg == ST_PRE) && pre_full;
  assign capture_active = capturing;
  assign done           = done_reg;

endmodule

// File: tb/tb_pretrig_capture_buffer.sv
// Directed bench for pretrig_capture_buffer: two instances (short pre-trigger
// off/on) share one stimulus stream; accepted words are collected and checked.
module tb_pretrig_capture_buffer;

  localparam int AW = 4;
  localparam int CH = 2;
  localparam int SW = 8;
  localparam int W  = CH * SW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic arm = 1'b0;
  logic abort = 1'b0;
  logic wr_ce = 1'b0;
  logic trigger = 1'b0;
  logic rd_ready = 1'b1;
  logic [AW:0] pre_samples = '0;
  logic [AW:0] total_samples = '0;
  logic [W-1:0] wr_data = '0;
  logic pre_filled0, capture_active0, done0;
  logic pre_filled1, capture_active1, done1;

  pretrig_capture_buffer_if #(.DATA_WIDTH(W)) bus0 ();
  pretrig_capture_buffer_if #(.DATA_WIDTH(W)) bus1 ();
  assign bus0.rd_ready = rd_ready;
  assign bus1.rd_ready = rd_ready;

  pretrig_capture_buffer #(
    .SAMPLE_WIDTH(SW), .CHANNELS(CH), .ADDR_WIDTH(AW), .ALLOW_SHORT_PRE(1'b0)
  ) dut0 (
    .clk(clk), .rst(rst), .arm(arm), .abort(abort),
    .pre_samples(pre_samples), .total_samples(total_samples),
    .wr_data(wr_data), .wr_ce(wr_ce), .trigger(trigger), .rd(bus0),
    .pre_filled(pre_filled0), .capture_active(capture_active0), .done(done0)
  );

  pretrig_capture_buffer #(
    .SAMPLE_WIDTH(SW), .CHANNELS(CH), .ADDR_WIDTH(AW), .ALLOW_SHORT_PRE(1'b1)
  ) dut1 (
    .clk(clk), .rst(rst), .arm(arm), .abort(abort),
    .pre_samples(pre_samples), .total_samples(total_samples),
    .wr_data(wr_data), .wr_ce(wr_ce), .trigger(trigger), .rd(bus1),
    .pre_filled(pre_filled1), .capture_active(capture_active1), .done(done1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass = 0;
  int n = 0;
  int edge_of_n [128];
  int done_cnt0 = 0, done_cnt1 = 0;
  logic [W-1:0] q_data0[$], q_data1[$];
  bit q_last0[$], q_last1[$];
  int q_cyc0[$], q_cyc1[$];
  logic stall0 = 1'b0, stall1 = 1'b0;
  logic [W:0] held0 = '0, held1 = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Accepted-word collector plus hold check while stalled.
  always @(negedge clk) begin
    if (!rst) begin
      if (stall0) chk("hold0", 32'({bus0.rd_valid, bus0.rd_last, bus0.rd_data}), 32'({1'b1, held0}));
      if (stall1) chk("hold1", 32'({bus1.rd_valid, bus1.rd_last, bus1.rd_data}), 32'({1'b1, held1}));
      if (bus0.rd_valid && rd_ready) begin
        q_data0.push_back(bus0.rd_data); q_last0.push_back(bus0.rd_last); q_cyc0.push_back(cyc);
      end
      if (bus1.rd_valid && rd_ready) begin
        q_data1.push_back(bus1.rd_data); q_last1.push_back(bus1.rd_last); q_cyc1.push_back(cyc);
      end
      if (done0) done_cnt0++;
      if (done1) done_cnt1++;
    end
    stall0 = bus0.rd_valid && !rd_ready && !rst && !abort;
    stall1 = bus1.rd_valid && !rd_ready && !rst && !abort;
    held0 = {bus0.rd_last, bus0.rd_data};
    held1 = {bus1.rd_last, bus1.rd_data};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    q_data0.delete(); q_last0.delete(); q_cyc0.delete();
    q_data1.delete(); q_last1.delete(); q_cyc1.delete();
  endtask

  task automatic arm_both(input int pre, input int total);
    clear_q();
    pre_samples = (AW + 1)'(pre);
    total_samples = (AW + 1)'(total);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    n = 0;
  endtask

  // ready_mode: 0 = held high, 1 = toggling, 2 = held low. stop_n < 0 waits for done on both.
  task automatic run(input int trig_a, input int trig_b, input int abort_at, input int stop_n, input int ready_mode);
    int d0;
    int d1;
    bit finished;
    d0 = done_cnt0 + 1;
    d1 = done_cnt1 + 1;
    finished = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (stop_n >= 0 ? (n >= stop_n) : (done_cnt0 >= d0 && done_cnt1 >= d1)) begin
        finished = 1'b1;
        break;
      end
      wr_data = {8'(n), 8'(n)};
      wr_ce = 1'b1;
      trigger = (n == trig_a) || (n == trig_b);
      abort = (n == abort_at);
      rd_ready = (ready_mode == 1) ? ~rd_ready : (ready_mode == 0);
      tick();
      if (n < 128) edge_of_n[n] = cyc;
      n++;
    end
    trigger = 1'b0;
    abort = 1'b0;
    rd_ready = 1'b1;
    chk("run_complete", 32'(finished), 32'd1);
  endtask

  task automatic check_rec(input string tag, input int which, input int first, input int count, input bit consec);
    logic [W-1:0] d[$];
    bit l[$];
    int c[$];
    if (which == 0) begin d = q_data0; l = q_last0; c = q_cyc0; end
    else begin d = q_data1; l = q_last1; c = q_cyc1; end
    chk({tag, "_count"}, 32'(d.size()), 32'(count));
    for (int i = 0; i < d.size() && i < count; i++) begin
      logic [W:0] e;
      e = {(i == count - 1), 8'(first + i), 8'(first + i)};
      chk({tag, "_word"}, 32'({l[i], d[i]}), 32'(e));
      if (consec && i > 0) chk({tag, "_gap"}, 32'(c[i]), 32'(c[i-1] + 1));
    end
    $display("%s: dut%0d read %0d words, expected %0d starting at %0d", tag, which, d.size(), count, first);
  endtask

  initial begin
    int exp_done0;
    int exp_done1;
    exp_done0 = 0;
    exp_done1 = 0;
    wr_ce = 1'b1;
    repeat (3) tick();
    chk("reset_valid", 32'({bus0.rd_valid, bus1.rd_valid}), 32'd0);
    chk("reset_last", 32'(bus0.rd_last), 32'd0);
    chk("reset_data", 32'(bus0.rd_data), 32'd0);
    chk("reset_flags", 32'({done0, capture_active0, pre_filled0}), 32'd0);
    rst = 1'b0;
    tick();

    // Basic capture, pre=4 total=10, trigger at 20
    arm_both(4, 10);
    chk("t1_active", 32'(capture_active0), 32'd1);
    run(-1, -1, -1, 3, 0);
    chk("t1_pre_not_full", 32'(pre_filled0), 32'd0);
    run(-1, -1, -1, 4, 0);
    chk("t1_pre_full", 32'(pre_filled0), 32'd1);
    run(20, -1, -1, -1, 0);
    exp_done0++; exp_done1++;
    check_rec("t1", 0, 16, 10, 1'b1);
    chk("t1_latency", (q_cyc0.size() > 0) ? 32'(q_cyc0[0]) : 32'hffff_ffff, 32'(edge_of_n[25] + 2));
    chk("t1_done", 32'(done_cnt0), 32'(exp_done0));
    chk("t1_idle", 32'({capture_active0, bus0.rd_valid}), 32'd0);

    // Short pre-trigger: dut0 ignores trigger at 2, dut1 accepts it
    arm_both(5, 10);
    run(2, 7, -1, -1, 0);
    exp_done0++; exp_done1++;
    check_rec("t2_strict", 0, 2, 10, 1'b1);
    check_rec("t2_short", 1, 0, 10, 1'b1);

    // Full-depth record wrapping the RAM twice
    arm_both(15, 16);
    run(40, -1, -1, -1, 0);
    exp_done0++; exp_done1++;
    check_rec("t3_wrap", 0, 25, 16, 1'b1);

    // Backpressure then full rate
    arm_both(3, 8);
    rd_ready = 1'b0;
    run(10, -1, -1, -1, 1);
    exp_done0++; exp_done1++;
    check_rec("t4_toggle", 0, 7, 8, 1'b0);
    arm_both(3, 8);
    run(10, -1, -1, -1, 0);
    exp_done0++; exp_done1++;
    check_rec("t4_stream", 0, 7, 8, 1'b1);
    chk("t4_done", 32'(done_cnt0), 32'(exp_done0));

    // Abort mid-POST, then a normal short record
    arm_both(4, 10);
    run(6, -1, 8, 12, 0);
    chk("t5_abort_idle", 32'({capture_active0, bus0.rd_valid}), 32'd0);
    chk("t5_abort_words", 32'(q_data0.size()), 32'd0);
    chk("t5_abort_nodone", 32'(done_cnt0), 32'(exp_done0));
    arm_both(2, 4);
    run(5, -1, -1, -1, 0);
    exp_done0++; exp_done1++;
    check_rec("t5_after", 0, 3, 4, 1'b1);

    // Reset while stalled in READ
    arm_both(3, 8);
    run(10, -1, -1, 20, 2);
    chk("t6_stalled_valid", 32'(bus0.rd_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", 32'({bus0.rd_valid, bus1.rd_valid}), 32'd0);
    chk("t6_rst_active", 32'(capture_active0), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("t6_rst_nodone", 32'(done_cnt0), 32'(exp_done0));
    chk("t6_rst_words", 32'(q_data0.size()), 32'd0);
    arm_both(2, 4);
    run(5, -1, -1, -1, 0);
    exp_done0++; exp_done1++;
    check_rec("t6_after", 0, 3, 4, 1'b1);

    // Clamping: total=0 -> 16, pre=20 -> 15
    arm_both(20, 0);
    run(30, -1, -1, -1, 0);
    exp_done0++; exp_done1++;
    check_rec("t7_clamp", 0, 15, 16, 1'b1);
    chk("t7_done0", 32'(done_cnt0), 32'(exp_done0));
    chk("t7_done1", 32'(done_cnt1), 32'(exp_done1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d, expected completion earlier", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pretrig_capture_buffer.md
# pretrig_capture_buffer

Single-clock, multi-channel pre/post-trigger capture buffer for the OpenADC sample path. It continuously stores samples into a circular RAM while armed and keeps a runtime-selected number of pre-trigger samples. On trigger it captures the remaining post-trigger samples, then streams the record out oldest-first over a valid/ready interface. It succeeds the fixed-ratio dual-clock capture FIFO. Channel count, sample width, depth, runtime pre/total counts, short-pretrigger mode and backpressured readout are all configurable.

## Interface
- SAMPLE_WIDTH, 10, bits per channel sample
- CHANNELS, 4, channels captured per sample strobe (1..8)
- ADDR_WIDTH, 11, RAM depth DEPTH = 2**ADDR_WIDTH sample sets
- ALLOW_SHORT_PRE, 0, 1 = accept trigger before the pre-trigger window is full
- clk  in  1  single clock for capture and readout
- rst  in  1  reset, asynchronous, active-high
- arm  in  1  pulse; starts a capture from IDLE
- abort  in  1  returns to IDLE from any state
- pre_samples  in  ADDR_WIDTH+1  requested pre-trigger sample sets, latched on arm
- total_samples  in  ADDR_WIDTH+1  record length, latched on arm
- wr_data  in  CHANNELS*SAMPLE_WIDTH  channel 0 in LSBs
- wr_ce  in  1  sample strobe
- trigger  in  1  qualified by wr_ce
- rd_data  out  CHANNELS*SAMPLE_WIDTH  readout word
- rd_valid  out  1  rd_data valid
- rd_ready  in  1  consumer accepts word
- rd_last  out  1  marks final word of record
- pre_filled  out  1  pre-trigger window full
- capture_active  out  1  state is PRE or POST
- done  out  1  one-cycle pulse after last word accepted

## Operation
- States: IDLE, PRE, POST, READ. All outputs reset to 0; state resets to IDLE.
- Clamping on arm: total = 0 or > DEPTH → DEPTH. pre ≥ total → total-1.
- IDLE + arm → PRE. wr_ptr, pre_cnt and post_cnt clear.
- PRE: each wr_ce writes wr_data at wr_ptr. wr_ptr increments mod DEPTH. pre_cnt saturates at pre. pre_filled = (pre_cnt == pre).
- Trigger with wr_ce in PRE:
  - Accepted if pre_filled or ALLOW_SHORT_PRE=1. That sample is the first post sample. pre_act = pre_cnt. State goes to POST.
  - Otherwise the trigger is ignored and the sample is stored normally.
- POST: on each wr_ce, write and count post_cnt. When post_cnt reaches total - pre_act, go to READ. Trigger is ignored in POST.
- Record start address = (trigger address - pre_act) mod DEPTH. Record length = total.
- READ: words are emitted in chronological order and wr_ce is ignored. rd_last is high on word `total`. Acceptance of the last word → IDLE, done = 1 for one cycle.
- abort: any state → IDLE on the next edge. rd_valid drops, no done. rst has the same effect asynchronously.
- arm outside IDLE is ignored.

## Timing
- RAM write occurs at the edge where wr_ce = 1, with zero added latency.
- Trigger at edge T → capture_active stays 1. The state reads POST after T.
- The final post sample is written at edge N and the state is READ after N. rd_valid first rises after edge N+2 (1-cycle RAM read plus output register).
- A 2-entry output skid buffer sustains 1 word/cycle with rd_ready held high. rd_data and rd_last are stable while rd_valid && !rd_ready.
- Pointer arithmetic is mod DEPTH. Counters are ADDR_WIDTH+1 bits, so total = DEPTH is representable.

## Structure
- Package pretrig_capture_pkg: state encoding constants and a clog2 function.
- Sub-module sdp_ram: simple dual-port RAM with a synchronous write port and a registered read port, width CHANNELS*SAMPLE_WIDTH, depth DEPTH.
- Top level contains the FSM, pointers, counters and skid buffer.

## Test plan
All scenarios use ADDR_WIDTH=4, CHANNELS=2, SAMPLE_WIDTH=8, wr_data = {n,n}, sample n = 0,1,2,…, wr_ce = 1 continuously.
- pre=4, total=10, trigger at n=20 → words 16..25, rd_last on 25, done pulse, state IDLE.
- ALLOW_SHORT_PRE=0, pre=5, total=10, trigger at n=2 and n=7 → n=2 ignored; read 2..11. With ALLOW_SHORT_PRE=1 and trigger at n=2 → read 0..9.
- pre=15, total=16, trigger at n=40 (wraps twice) → words 25..40, no gaps or duplicates.
- pre=3, total=8, rd_ready toggles 1,0,1,0 → exactly 8 words in order. With rd_ready held 1 → 8 words on 8 consecutive cycles.
- abort asserted mid-POST, and separately rst mid-READ → IDLE, rd_valid = 0, no done pulse. A following arm with pre=2, total=4 completes normally.
- total=0, pre=20 → clamped to total=16, pre=15. Trigger at n=30 → words 15..30.
